// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM arbiter.
package sdram_arb_pkg;
    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_PLAY = 2'd1,
        GNT_REC  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_PLAY = 1'b0,
        OWN_REC  = 1'b1
    } owner_e;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between playback core, record core, arbiter and SDRAM controller.
// slave: arbiter side; master: surrounding system (cores + controller).
interface sdram_arbiter_if;
    import sdram_arb_pkg::*;

    logic              play_read;
    logic [ADDR_W-1:0] play_addr;
    logic [DATA_W-1:0] play_readdata;
    logic              play_sdram_finished;

    logic              rec_write;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_writedata;
    logic              rec_sdram_finished;

    logic              sdram_read;
    logic              sdram_write;
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_writedata;
    logic [DATA_W-1:0] sdram_readdata;
    logic              sdram_finished;

    logic              arb_busy;
    logic              arb_timeout;

    modport slave (
        input  play_read, play_addr, rec_write, rec_addr, rec_writedata,
               sdram_readdata, sdram_finished,
        output play_readdata, play_sdram_finished, rec_sdram_finished,
               sdram_read, sdram_write, sdram_addr, sdram_writedata,
               arb_busy, arb_timeout
    );

    modport master (
        output play_read, play_addr, rec_write, rec_addr, rec_writedata,
               sdram_readdata, sdram_finished,
        input  play_readdata, play_sdram_finished, rec_sdram_finished,
               sdram_read, sdram_write, sdram_addr, sdram_writedata,
               arb_busy, arb_timeout
    );
endinterface

// File: rtl/sdram_arbiter_rr_picker2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whoever was not served last. req[0] = playback, req[1] = record.
module rr_picker2
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] grant
);
    // One-hot grant; req passes through unless both are asking.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = (last == OWN_REC) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM arbiter between a playback (read) core and a record (write) core.
// Optional grant watchdog enabled with macro SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           i_clk,
    input  logic           i_rst,
    sdram_arbiter_if.slave bus
);
    arb_state_e state_q, state_d;
    owner_e     last_q, last_d;
    logic [1:0] grant;
    logic       timeout_hit;

    rr_picker2 u_rr (
        .req   ({bus.rec_write, bus.play_read}),
        .last  (last_q),
        .grant (grant)
    );

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             to_q;

    assign timeout_hit     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.arb_timeout = to_q;

    // Grant-age counter, zero on the first grant cycle; abort pulse lands
    // in the IDLE cycle that follows the forced release.
    always_ff @(posedge i_clk) begin
        if (i_rst || state_q == IDLE) cnt_q <= '0;
        else                          cnt_q <= cnt_q + 1'b1;
        to_q <= !i_rst && (state_q != IDLE) && !bus.sdram_finished && timeout_hit;
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus.arb_timeout = 1'b0;
`endif

    // State and last-served owner; playback wins the first tie after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= OWN_REC;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next state: grants only leave on finished (or watchdog), never on a
    // dropped request; every release passes through IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (grant[0])      state_d = GNT_PLAY;
                else if (grant[1]) state_d = GNT_REC;
            end
            GNT_PLAY: begin
                if (bus.sdram_finished || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = OWN_PLAY;
                end
            end
            GNT_REC: begin
                if (bus.sdram_finished || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = OWN_REC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command mux and finished routing, decoded from the registered state.
    always_comb begin
        bus.sdram_read          = 1'b0;
        bus.sdram_write         = 1'b0;
        bus.sdram_addr          = '0;
        bus.sdram_writedata     = '0;
        bus.play_sdram_finished = 1'b0;
        bus.rec_sdram_finished  = 1'b0;
        bus.arb_busy            = 1'b0;
        case (state_q)
            GNT_PLAY: begin
                bus.sdram_read          = 1'b1;
                bus.sdram_addr          = bus.play_addr;
                bus.play_sdram_finished = bus.sdram_finished;
                bus.arb_busy            = 1'b1;
            end
            GNT_REC: begin
                bus.sdram_write        = 1'b1;
                bus.sdram_addr         = bus.rec_addr;
                bus.sdram_writedata    = bus.rec_writedata;
                bus.rec_sdram_finished = bus.sdram_finished;
                bus.arb_busy           = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.play_readdata = bus.sdram_readdata;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: each issued request pushes the
// expected command; a monitor pops it when the DUT starts a grant.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic              is_rec;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_cmd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic is_rec, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.is_rec = is_rec;
        e.addr   = a;
        e.data   = is_rec ? d : '0;
        sb.push_back(e);
    endtask

    // Monitor: first cycle of each command is checked against the scoreboard.
    always @(negedge i_clk) begin
        logic cmd;
        exp_t e;
        cmd = bus.sdram_read | bus.sdram_write;
        if (cmd && !prev_cmd) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("sb_kind", {31'd0, bus.sdram_write}, {31'd0, e.is_rec});
                chk("sb_addr", {9'd0, bus.sdram_addr}, {9'd0, e.addr});
                chk("sb_wdata", bus.sdram_writedata, e.data);
            end
        end
        prev_cmd = cmd;
    end

    task automatic do_reset();
        bus.sdram_readdata = 32'hA5A5_A5A5;
        i_rst = 1'b1;
        step();
        step();
        chk("rst_busy", {31'd0, bus.arb_busy}, 32'd0);
        chk("rst_cmd", {30'd0, bus.sdram_read, bus.sdram_write}, 32'd0);
        chk("rst_addr", {9'd0, bus.sdram_addr}, 32'd0);
        chk("rst_wdata", bus.sdram_writedata, 32'd0);
        chk("rst_fin", {30'd0, bus.play_sdram_finished, bus.rec_sdram_finished}, 32'd0);
        chk("rst_to", {31'd0, bus.arb_timeout}, 32'd0);
        chk("rst_rdata", bus.play_readdata, 32'hA5A5_A5A5);
        i_rst = 1'b0;
        step();
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!(bus.sdram_read || bus.sdram_write) && n < 20) begin
            step();
            n++;
        end
        chk("cmd_seen", {31'd0, bus.sdram_read | bus.sdram_write}, 32'd1);
    endtask

    task automatic grant_and_finish(input logic is_rec, input logic [31:0] rdata);
        chk("gf_busy", {31'd0, bus.arb_busy}, 32'd1);
        chk("gf_read", {31'd0, bus.sdram_read}, {31'd0, !is_rec});
        chk("gf_write", {31'd0, bus.sdram_write}, {31'd0, is_rec});
        bus.sdram_readdata = rdata;
        bus.sdram_finished = 1'b1;
        #1;
        chk("gf_pfin", {31'd0, bus.play_sdram_finished}, {31'd0, !is_rec});
        chk("gf_rfin", {31'd0, bus.rec_sdram_finished}, {31'd0, is_rec});
        chk("gf_rdata", bus.play_readdata, rdata);
        step();
        bus.sdram_finished = 1'b0;
        if (is_rec) bus.rec_write = 1'b0;
        else        bus.play_read = 1'b0;
        #1;
        chk("gf_idle", {31'd0, bus.arb_busy}, 32'd0);
        chk("gf_fin0", {30'd0, bus.play_sdram_finished, bus.rec_sdram_finished}, 32'd0);
    endtask

    task automatic tie_pair(input logic [ADDR_W-1:0] pa, input logic [ADDR_W-1:0] ra,
                            input logic [DATA_W-1:0] rd);
        int n;
        bus.play_addr = pa;
        bus.rec_addr = ra;
        bus.rec_writedata = rd;
        push(1'b0, pa, '0);
        push(1'b1, ra, rd);
        bus.play_read = 1'b1;
        bus.rec_write = 1'b1;
        wait_cmd(n);
        chk("tie_lat", n, 32'd1);
        chk("tie_play_first", {31'd0, bus.sdram_read}, 32'd1);
        grant_and_finish(1'b0, 32'h1111_0000 ^ {9'd0, pa});
        wait_cmd(n);
        chk("tie_rec_lat", n, 32'd1);
        grant_and_finish(1'b1, 32'h0);
    endtask

    initial begin
        int n;
        int pf_seen;
        bus.play_read = 1'b0;
        bus.play_addr = '0;
        bus.rec_write = 1'b0;
        bus.rec_addr = '0;
        bus.rec_writedata = '0;
        bus.sdram_finished = 1'b0;
        bus.sdram_readdata = '0;

        do_reset();

        // Single playback read.
        bus.play_addr = 23'h000010;
        push(1'b0, 23'h000010, '0);
        bus.play_read = 1'b1;
        wait_cmd(n);
        chk("t1_lat", n, 32'd1);
        chk("t1_addr", {9'd0, bus.sdram_addr}, 32'h10);
        grant_and_finish(1'b0, 32'hDEAD_BEEF);

        // Ties after reset: play, then rec, then play wins again.
        do_reset();
        tie_pair(23'h000100, 23'h000200, 32'hCAFE_0001);
        tie_pair(23'h000300, 23'h000400, 32'hCAFE_0002);

        // Record write at top address.
        bus.rec_addr = 23'h7FFFFF;
        bus.rec_writedata = 32'h1234_5678;
        push(1'b1, 23'h7FFFFF, 32'h1234_5678);
        bus.rec_write = 1'b1;
        wait_cmd(n);
        chk("t3_wdata", bus.sdram_writedata, 32'h1234_5678);
        grant_and_finish(1'b1, 32'h0);

        // Request dropped mid-grant keeps the grant.
        bus.play_addr = 23'h000055;
        push(1'b0, 23'h000055, '0);
        bus.play_read = 1'b1;
        wait_cmd(n);
        bus.play_read = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
        repeat (3) step();
`else
        repeat (12) step();
        chk("drop_no_to", {31'd0, bus.arb_timeout}, 32'd0);
`endif
        chk("drop_busy", {31'd0, bus.arb_busy}, 32'd1);
        chk("drop_read", {31'd0, bus.sdram_read}, 32'd1);
        grant_and_finish(1'b0, 32'h5555_AAAA);

        // Finished in IDLE is ignored.
        bus.sdram_finished = 1'b1;
        #1;
        chk("idle_fin", {30'd0, bus.play_sdram_finished, bus.rec_sdram_finished}, 32'd0);
        step();
        chk("idle_busy", {31'd0, bus.arb_busy}, 32'd0);
        bus.sdram_finished = 1'b0;

        // Reset mid-grant on a record write.
        bus.rec_addr = 23'h000777;
        bus.rec_writedata = 32'h0BAD_F00D;
        push(1'b1, 23'h000777, 32'h0BAD_F00D);
        bus.rec_write = 1'b1;
        wait_cmd(n);
        chk("r37_write", {31'd0, bus.sdram_write}, 32'd1);
        i_rst = 1'b1;
        step();
        chk("r37_drop", {31'd0, bus.sdram_write}, 32'd0);
        chk("r37_busy", {31'd0, bus.arb_busy}, 32'd0);
        bus.sdram_finished = 1'b1;
        #1;
        chk("r37_fin", {30'd0, bus.play_sdram_finished, bus.rec_sdram_finished}, 32'd0);
        bus.sdram_finished = 1'b0;
        bus.rec_write = 1'b0;
        step();
        i_rst = 1'b0;
        step();
        tie_pair(23'h000500, 23'h000600, 32'hCAFE_0003);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Watchdog aborts a stalled grant; pending rec goes next.
        do_reset();
        bus.play_addr = 23'h000900;
        bus.rec_addr = 23'h000A00;
        bus.rec_writedata = 32'hFACE_0000;
        push(1'b0, 23'h000900, '0);
        push(1'b1, 23'h000A00, 32'hFACE_0000);
        bus.play_read = 1'b1;
        bus.rec_write = 1'b1;
        wait_cmd(n);
        chk("to_play", {31'd0, bus.sdram_read}, 32'd1);
        n = 0;
        pf_seen = 0;
        while (!bus.arb_timeout && n < 20) begin
            step();
            n++;
            if (bus.play_sdram_finished) pf_seen++;
        end
        chk("to_lat", n, 32'd8);
        chk("to_nofin", pf_seen, 32'd0);
        chk("to_idle", {31'd0, bus.arb_busy}, 32'd0);
        bus.play_read = 1'b0;
        wait_cmd(n);
        chk("to_rec_lat", n, 32'd1);
        chk("to_pulse1", {31'd0, bus.arb_timeout}, 32'd0);
        grant_and_finish(1'b1, 32'h0);
`else
        pf_seen = 0;
        chk("no_to", {31'd0, bus.arb_timeout}, pf_seen);
`endif

        step();
        step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
